// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED blink sequencer.
//
// Contents:
//   state_e   - sequencer FSM state (StIdle, StOn, StOff)
//   ON_W      - width of the ON/OFF phase length and unit counter
//   CNT_W     - width of the blink-cycle count and cycle counter
//   DUTY_W    - width of the PWM duty value and PWM counter
//   eff_len() - maps a latched phase length of 0 to 1 unit

package led_seq_pkg;

    localparam int unsigned ON_W   = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DUTY_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    // A phase of 0 units would never end on a unit boundary, so run it as 1 unit.
    function automatic logic [ON_W-1:0] eff_len(input logic [ON_W-1:0] len);
        return (len == '0) ? ON_W'(1) : len;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing one time-unit tick every TICK_DIV clock cycles.
//
// Parameters:
//   TICK_DIV - clk cycles per time unit (2 .. 2^20)
// Ports:
//   clk     - clock, posedge
//   rst     - synchronous active-high reset
//   clr_i   - holds the prescaler at zero (and suppresses the tick) while high
//   tick_o  - high on the last cycle of each time unit

module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] Last = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == Last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == Last);

endmodule

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: blinks led0 with programmable ON/OFF lengths for a
// programmable number of cycles (or forever), with a valid/ready config port.
//
// Optional feature macro: LED_SEQ_PWM_EN adds cfg_duty and dims led0 during ON
// with a free-running 4-bit PWM counter.
//
// Parameters:
//   TICK_DIV  - clk cycles per time unit
// Ports:
//   clk       - clock, posedge
//   rst       - synchronous active-high reset
//   cfg_valid - config offer; transfer when cfg_valid && cfg_ready
//   cfg_ready - high iff idle
//   cfg_on    - ON phase length in units (0 behaves as 1)
//   cfg_off   - OFF phase length in units (0 behaves as 1)
//   cfg_count - blink cycles per run, 0 = until stop
//   cfg_duty  - PWM duty during ON, 15 = fully on (LED_SEQ_PWM_EN only)
//   start     - level run request, honoured only when idle
//   stop      - abort, highest priority after rst
//   led0      - registered LED drive
//   busy      - high in ON or OFF
//   done      - one-cycle pulse on normal completion

module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ON_W-1:0]   cfg_on,
    input  logic [ON_W-1:0]   cfg_off,
    input  logic [CNT_W-1:0]  cfg_count,
`ifdef LED_SEQ_PWM_EN
    input  logic [DUTY_W-1:0] cfg_duty,
`endif
    input  logic              start,
    input  logic              stop,
    output logic              led0,
    output logic              busy,
    output logic              done
);

    state_e state_q, state_d;

    logic [ON_W-1:0]  on_q, on_d;
    logic [ON_W-1:0]  off_q, off_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ON_W-1:0]  unit_q, unit_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             led0_q, led0_d;
    logic             done_q, done_d;

`ifdef LED_SEQ_PWM_EN
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] pwm_q, pwm_d;
`endif

    logic cfg_xfer;
    logic tick;

    // The prescaler is held cleared while idle, so each run starts on a unit boundary.
    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == StIdle),
        .tick_o (tick)
    );

    assign cfg_ready = (state_q == StIdle);
    assign cfg_xfer  = cfg_valid && cfg_ready;

    always_comb begin
        state_d = state_q;
        on_d    = on_q;
        off_d   = off_q;
        count_d = count_q;
        unit_d  = unit_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;
        led0_d  = 1'b0;
`ifdef LED_SEQ_PWM_EN
        duty_d  = duty_q;
        pwm_d   = pwm_q + DUTY_W'(1);
`endif

        if (cfg_xfer) begin
            on_d    = cfg_on;
            off_d   = cfg_off;
            count_d = cfg_count;
`ifdef LED_SEQ_PWM_EN
            duty_d  = cfg_duty;
`endif
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StOn;
                    unit_d  = '0;
                    cyc_d   = '0;
                end
            end
            StOn: begin
                if (tick) begin
                    if (unit_q == eff_len(on_q) - ON_W'(1)) begin
                        state_d = StOff;
                        unit_d  = '0;
                    end else begin
                        unit_d = unit_q + ON_W'(1);
                    end
                end
            end
            StOff: begin
                if (tick) begin
                    if (unit_q == eff_len(off_q) - ON_W'(1)) begin
                        unit_d = '0;
                        // With count_q == 0 the counter simply wraps and the run never ends.
                        cyc_d  = cyc_q + CNT_W'(1);
                        if ((count_q != '0) && (cyc_d == count_q)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StOn;
                        end
                    end else begin
                        unit_d = unit_q + ON_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (stop) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end

        // led0 is registered, so it is driven from the state being entered.
`ifdef LED_SEQ_PWM_EN
        led0_d = (state_d == StOn) && ((duty_d == '1) || (pwm_d < duty_d));
`else
        led0_d = (state_d == StOn);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            on_q    <= ON_W'(1);
            off_q   <= ON_W'(1);
            count_q <= CNT_W'(1);
            unit_q  <= '0;
            cyc_q   <= '0;
            led0_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LED_SEQ_PWM_EN
            duty_q  <= '1;
            pwm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            off_q   <= off_d;
            count_q <= count_d;
            unit_q  <= unit_d;
            cyc_q   <= cyc_d;
            led0_q  <= led0_d;
            done_q  <= done_d;
`ifdef LED_SEQ_PWM_EN
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
`endif
        end
    end

    assign led0 = led0_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: directed self-checking bench for led_blink_sequencer
// with TICK_DIV=4. Inputs change on the falling edge; outputs are sampled on the
// falling edge. Cycle k=1 is the first cycle after the edge that sampled start.

module tb_led_blink_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_on;
    logic [15:0] cfg_off;
    logic [7:0]  cfg_count;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]  cfg_duty;
`endif
    logic        start;
    logic        stop;
    logic        led0;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_blink_sequencer #(
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_on    (cfg_on),
        .cfg_off   (cfg_off),
        .cfg_count (cfg_count),
`ifdef LED_SEQ_PWM_EN
        .cfg_duty  (cfg_duty),
`endif
        .start     (start),
        .stop      (stop),
        .led0      (led0),
        .busy      (busy),
        .done      (done)
    );

    // Offer a config and a start in the same cycle; the caller drops both at k=1.
    task automatic start_run(input logic [15:0] on, input logic [15:0] off,
                             input logic [7:0] cnt);
        @(negedge clk);
        cfg_on    = on;
        cfg_off   = off;
        cfg_count = cnt;
        cfg_valid = 1'b1;
        start     = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({led0, busy, done, cfg_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset outs {led0,busy,done,rdy} got=%b exp=0001",
                     {led0, busy, done, cfg_ready});
        end
        rst = 1'b0;
    endtask

    // on=2, off=3, count=2: ON 1..8, OFF 9..20, ON 21..28, OFF 29..40, done at 41.
    task automatic test_basic;
        logic el, eb, ed;
        start_run(16'd2, 16'd3, 8'd2);
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            el = (k <= 8) || (k >= 21 && k <= 28);
            eb = (k <= 40);
            ed = (k == 41);
            total++;
            if ({led0, busy, done, cfg_ready} !== {el, eb, ed, !eb}) begin
                bad++;
                $display("FAIL basic k=%0d {led0,busy,done,rdy} got=%b exp=%b",
                         k, {led0, busy, done, cfg_ready}, {el, eb, ed, !eb});
            end
        end
    endtask

    // Zero lengths behave as one unit: 4 cycles ON, 4 OFF, done at 9.
    task automatic test_zero_len;
        logic el, eb, ed;
        start_run(16'd0, 16'd0, 8'd1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            el = (k <= 4);
            eb = (k <= 8);
            ed = (k == 9);
            total++;
            if ({led0, busy, done} !== {el, eb, ed}) begin
                bad++;
                $display("FAIL zero_len k=%0d {led0,busy,done} got=%b exp=%b",
                         k, {led0, busy, done}, {el, eb, ed});
            end
        end
    endtask

    // count=0 repeats indefinitely; stop during an OFF phase ends it.
    task automatic test_repeat;
        logic el;
        start_run(16'd0, 16'd0, 8'd0);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            if (k <= 40) begin
                el = (((k - 1) % 8) < 4);
                total++;
                if ({led0, busy, done} !== {el, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL repeat k=%0d {led0,busy,done} got=%b exp=%b",
                             k, {led0, busy, done}, {el, 1'b1, 1'b0});
                end
                if (k == 40) stop = 1'b1;
            end else begin
                stop = 1'b0;
                total++;
                if ({led0, busy, done, cfg_ready} !== 4'b0001) begin
                    bad++;
                    $display("FAIL repeat_stop {led0,busy,done,rdy} got=%b exp=0001",
                             {led0, busy, done, cfg_ready});
                end
            end
        end
    endtask

    // on=5 gives a 20-cycle ON; stop at k=10 is mid-ON.
    task automatic test_stop;
        start_run(16'd5, 16'd3, 8'd0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            if (k <= 10) begin
                total++;
                if ({led0, busy, done} !== 3'b110) begin
                    bad++;
                    $display("FAIL stop_run k=%0d {led0,busy,done} got=%b exp=110",
                             k, {led0, busy, done});
                end
                if (k == 10) stop = 1'b1;
            end else begin
                stop = 1'b0;
                total++;
                if ({led0, busy, done, cfg_ready} !== 4'b0001) begin
                    bad++;
                    $display("FAIL stop_after k=%0d {led0,busy,done,rdy} got=%b exp=0001",
                             k, {led0, busy, done, cfg_ready});
                end
            end
        end
    endtask

    // A config offered while busy is refused and does not alter the timing.
    task automatic test_busy_cfg;
        logic el, eb, ed;
        start_run(16'd2, 16'd3, 8'd1);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            if (k == 3) begin
                cfg_on    = 16'd5;
                cfg_valid = 1'b1;
                total++;
                if (cfg_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_cfg ready got=%b exp=0", cfg_ready);
                end
            end
            if (k == 6) cfg_valid = 1'b0;
            el = (k <= 8);
            eb = (k <= 20);
            ed = (k == 21);
            total++;
            if ({led0, busy, done} !== {el, eb, ed}) begin
                bad++;
                $display("FAIL busy_cfg k=%0d {led0,busy,done} got=%b exp=%b",
                         k, {led0, busy, done}, {el, eb, ed});
            end
        end
        // Restart without a transfer: shadow on must still be 2, not 5.
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            el = (k <= 8);
            total++;
            if (led0 !== el) begin
                bad++;
                $display("FAIL busy_cfg_rerun k=%0d led0 got=%b exp=%b", k, led0, el);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Reset in OFF with start and cfg_valid also high; then defaults 1/1/1 apply.
    task automatic test_reset_mid;
        logic el, eb, ed;
        start_run(16'd2, 16'd3, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
        end
        total++;
        if ({led0, busy} !== 2'b01) begin
            bad++;
            $display("FAIL reset_mid pre {led0,busy} got=%b exp=01", {led0, busy});
        end
        rst       = 1'b1;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_on    = 16'd7;
        @(negedge clk);
        total++;
        if ({led0, busy, done, cfg_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid outs {led0,busy,done,rdy} got=%b exp=0001",
                     {led0, busy, done, cfg_ready});
        end
        rst       = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid idle busy got=%b exp=0", busy);
        end
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            el = (k <= 4);
            eb = (k <= 8);
            ed = (k == 9);
            total++;
            if ({led0, busy, done} !== {el, eb, ed}) begin
                bad++;
                $display("FAIL reset_defaults k=%0d {led0,busy,done} got=%b exp=%b",
                         k, {led0, busy, done}, {el, eb, ed});
            end
        end
    endtask

`ifdef LED_SEQ_PWM_EN
    task automatic test_pwm;
        int highs;
        cfg_duty = 4'd4;
        start_run(16'd5, 16'd1, 8'd1);
        highs = 0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            if (k <= 16 && led0 === 1'b1) highs++;
        end
        total++;
        if (highs != 4) begin
            bad++;
            $display("FAIL pwm_duty4 highs got=%0d exp=4", highs);
        end
        cfg_duty = 4'd15;
        start_run(16'd5, 16'd1, 8'd1);
        highs = 0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
            if (k <= 20 && led0 === 1'b1) highs++;
        end
        total++;
        if (highs != 20) begin
            bad++;
            $display("FAIL pwm_duty15 highs got=%0d exp=20", highs);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_on    = '0;
        cfg_off   = '0;
        cfg_count = '0;
`ifdef LED_SEQ_PWM_EN
        cfg_duty  = 4'd15;
`endif
        start     = 1'b0;
        stop      = 1'b0;

        test_reset();
        test_basic();
        test_zero_len();
        test_repeat();
        test_stop();
        test_busy_cfg();
        test_reset_mid();
`ifdef LED_SEQ_PWM_EN
        test_pwm();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_blink_sequencer.md
LED_BLINK_SEQUENCER -- requirements
Module: led_blink_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per time unit (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 clk  in  1  single clock; all logic is posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cfg_valid  in  1  config offer; a transfer occurs on a cycle where cfg_valid && cfg_ready.
REQ-005 cfg_ready  out  1  config acceptance; high iff state is IDLE.
REQ-006 cfg_on  in  16  ON phase length in time units.
REQ-007 cfg_off  in  16  OFF phase length in time units.
REQ-008 cfg_count  in  8  blink cycles per run; 0 means repeat until stop.
REQ-009 start  in  1  level-sampled run request; acted on only in IDLE.
REQ-010 stop  in  1  abort request; acted on in any state.
REQ-011 led0  out  1  registered LED drive.
REQ-012 busy  out  1  high iff state is ON or OFF.
REQ-013 done  out  1  one-cycle pulse on normal run completion.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ON and OFF.
REQ-015 Config transfer SHALL latch cfg_on, cfg_off and cfg_count into shadow registers; these registers hold their values across runs until the next transfer.
REQ-016 A latched phase length of 0 SHALL be treated as 1 unit.
REQ-017 If a config transfer and start occur in the same cycle, the run SHALL use the newly transferred values.
REQ-018 On start in IDLE (cycle t), the FSM SHALL enter ON at t+1 and clear the prescaler, the unit counter and the cycle counter.
REQ-019 ON SHALL last exactly on*TICK_DIV cycles, with led0=1 throughout (see REQ-027); the FSM SHALL then enter OFF for exactly off*TICK_DIV cycles with led0=0.
REQ-020 At the end of an OFF phase, the cycle counter SHALL increment; if cfg_count!=0 and the incremented value equals cfg_count, the FSM SHALL go to IDLE and pulse done that cycle; otherwise it SHALL return to ON.
REQ-021 The prescaler SHALL wrap at TICK_DIV-1; the unit counter SHALL reset at every phase change; the 8-bit cycle counter SHALL wrap silently when cfg_count=0.
REQ-022 Stop SHALL take priority over every other event: the next state is IDLE, led0=0 the next cycle, and no done pulse is issued.
REQ-023 While busy, start SHALL be ignored and cfg_valid SHALL be left unacknowledged.
REQ-024 led0 SHALL be 0 in IDLE.

Reset
REQ-025 On rst: state=IDLE, led0=0, busy=0, done=0, cfg_ready=1, all counters=0, shadow registers on=1, off=1, count=1.
REQ-026 rst SHALL override stop, start and cfg_valid; a mid-run reset ends the run with no done pulse.

Configuration
REQ-027 With LED_SEQ_PWM_EN defined:
- Input cfg_duty[3:0] is added and latched on config transfer (reset value 15).
- A 4-bit free-running pwm counter is added.
- During ON, led0 = (duty==15) || (pwm_cnt < duty).
REQ-028 Without LED_SEQ_PWM_EN: the cfg_duty port and pwm counter are absent, and led0=1 throughout ON.

Structure
REQ-029 Package led_seq_pkg SHALL hold:
- the state enum (IDLE, ON, OFF)
- the width constants ON_W=16, CNT_W=8, DUTY_W=4
REQ-030 Sub-module led_tick_gen (prescaler with a TICK_DIV parameter, clear input and tick output) SHALL generate the unit tick.

Verification (TICK_DIV=4)
REQ-031 cfg on=2, off=3, count=2, then start at t:
- led0 high t+1..t+8
- led0 low t+9..t+20
- led0 high t+9+12..t+28 (second ON)
- done pulses once at the final OFF end; busy then 0 and cfg_ready 1
REQ-032 cfg on=0, off=0, count=1, then start -> led0 high 4 cycles, low 4 cycles, then done.
REQ-033 count=0, run 10 cycles, then stop mid-ON -> led0=0 and state IDLE next cycle, done never asserted.
REQ-034 cfg_valid with new on=5 while busy -> cfg_ready=0, no transfer; the current run keeps its old timing.
REQ-035 rst asserted mid-OFF together with start -> all outputs at reset values the next cycle, with no run begun.
REQ-036 With LED_SEQ_PWM_EN and duty=4 -> during ON, led0 high exactly 4 of every 16 cycles; duty=15 -> constantly high.
